if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch initiator for the instruction memory. Drives the fetch
//  address every cycle and takes the returned word combinationally in the same
//  cycle. Buffers {pc, instr} pairs in a small FIFO and presents them to the
//  decode stage over a valid/ready handshake. Handles back-pressure from decode
//  and PC redirects from branch/jump resolution.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset; must be word-aligned
//  FIFO_DEPTH  2              buffer entries; power of two, >= 2
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   asynchronous reset, active-high
//  pc_out          out  32  fetch address to instruction memory (= fetch_pc register)
//  code_in         in   32  instruction word at pc_out, valid in the same cycle
//  redirect_valid  in   1   load a new fetch PC this cycle; flushes the buffer
//  redirect_pc     in   32  target address when redirect_valid=1
//  out_valid       out  1   head FIFO entry is available to decode
//  out_ready       in   1   decode accepts the head entry
//  out_instr       out  32  instruction word of the head entry
//  out_pc          out  32  address of the head entry
//  fetch_fault     out  1   only with IF_ALIGN_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, rst=1): fetch_pc=RESET_PC, count=0, rd/wr ptr=0,
//    out_valid=0, fetch_fault=0. out_instr and out_pc read the empty head
//    entry; their value is don't-care while out_valid=0.
//  - pop  = out_valid & out_ready & ~redirect_valid.
//  - push = ~redirect_valid & (count<FIFO_DEPTH | pop). A push writes
//    {fetch_pc, code_in} at wr_ptr, then fetch_pc <= fetch_pc+4.
//  - Push and pop in the same cycle: count is unchanged and both pointers advance.
//  - Full and no pop: no push, and fetch_pc holds. The same address is refetched
//    next cycle.
//  - out_valid = (count!=0) & ~redirect_valid. Decode never takes a stale entry
//    during a redirect.
//  - Redirect has top priority. count<=0 and pointers<=0. fetch_pc<=redirect_pc
//    (bits[1:0] handling per CONFIGURATION). There is no push and no pop that cycle.
//  - Latency: the word is captured in the cycle pc_out is presented, and out_valid
//    rises on the next cycle. From reset release or redirect to first out_valid is
//    1 cycle. Throughput is 1 instr/cycle while out_ready=1.
//  - fetch_pc wraps modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is
//    log2(FIFO_DEPTH)+1 bits.
//  - Reset asserted mid-stream discards all buffered entries immediately
//    (asynchronous).
// CONFIGURATION
//  IF_ALIGN_CHECK_EN defined:
//    - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until rst).
//    - While fetch_fault=1: fetching stops, there are no further pushes, and
//      out_valid drains the remaining entries only.
//  IF_ALIGN_CHECK_EN undefined:
//    - fetch_pc <= {redirect_pc[31:2],2'b00}.
//    - fetch_fault is tied to 0.
// TESTING
//  1 reset, out_ready=1, IM words w0..w3 -> out_pc 0,4,8,C on consecutive
//    cycles, out_valid first high 1 cycle after reset release.
//  2 out_ready=0 for 5 cycles -> count saturates at 2, pc_out holds at 8; then
//    out_ready=1 -> pcs 0,4,8,... delivered in order, none lost or duplicated.
//  3 redirect_valid=1, redirect_pc=0x40 while full -> out_valid=0 that cycle;
//    next out_pc=0x40, followed by 0x44.
//  4 redirect_pc=0xFFFF_FFFC, out_ready=1 -> out_pc 0xFFFF_FFFC then 0x0000_0000.
//  5 rst pulsed mid-stream with count=2 -> out_valid=0 immediately; after release
//    out_pc restarts at RESET_PC.
//  6 redirect_pc=0x42: with IF_ALIGN_CHECK_EN, fetch_fault=1 and no new entries;
//    without it, next out_pc=0x40.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: drives pc_out, buffers {pc, instr} pairs and hands them to decode.
// Define IF_ALIGN_CHECK_EN to fault (sticky) on misaligned redirects; otherwise targets are aligned.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] code_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fault_q;
  logic            push, pop;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];

  always_comb begin
    out_valid  = (count_q != '0) & ~redirect_valid;
    pop        = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full buffer still streams.
    push       = ~redirect_valid & ~fault_q & ((count_q < DepthCnt) | pop);
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign fault_q = 1'b0;
`endif

  // Storage needs no reset: count gates every read through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= code_in;
    end
  end

  assign pc_out      = fetch_pc_q;
  assign out_pc      = pc_mem[rd_ptr_q];
  assign out_instr   = instr_mem[rd_ptr_q];
  assign fetch_fault = fault_q;

endmodule
